mmio_input_port: RTL and testbench

- Memory-mapped input peripheral on the CPU data bus, next to dataRAM and the HEX display register.
- The display path is CPU-written; this block is the CPU-read path for board inputs: 10 slide switches and 4 push-buttons.
- Provides synchronized switch state, debounced key state, and a write-1-to-clear key-press capture register, with an optional interrupt output.
- Read data is registered, giving the same 1-cycle latency as dataRAM, so the bus mux treats both sources identically.

---
 rtl/mmio_input_port.sv | 148 ++++++++++++++
 tb/tb_mmio_input_port.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_input_port.sv
// mmio_input_port: CPU-read peripheral for the board's slide switches and
// push-buttons. Exposes synchronized switches, debounced key state, a
// write-1-to-clear press-capture register and (optionally) a masked irq.
// Read data is registered so it lines up with the dataRAM read latency.
//
// Build option: define MMIO_INPUT_IRQ_EN to implement the IRQ_MASK register
// and the registered irq output; otherwise IRQ_MASK reads 0 and irq is 0.
//
// Offset map from BASE_ADDR:
//   +0 SW_STATE  RO    {22'b0, synced SW}
//   +1 KEY_STATE RO    {28'b0, debounced pressed}
//   +2 KEY_EDGE  RW1C  {28'b0, press capture}
//   +3 IRQ_MASK  RW    {28'b0, mask}
module mmio_input_port #(
   parameter logic [13:0] BASE_ADDR       = 14'h3FF8,
   parameter int          DEBOUNCE_CYCLES = 50000
) (
   input  logic        clk,
   input  logic        nRst,
   input  logic [13:0] dataAddress,
   input  logic [31:0] writeDataIn,
   input  logic        dataWrEn,
   input  logic [9:0]  SW,
   input  logic [3:0]  KEY,
   output logic [31:0] readDataOut,
   output logic        readHit,
   output logic        irq
);

   localparam int              CNT_W  = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [9:0]       sw_meta, sw_sync;
   logic [3:0]       key_meta, key_sync;
   logic [3:0]       key_pressed_sync;
   logic [3:0]       key_stable;
   logic [CNT_W-1:0] db_cnt [4];
   logic [3:0]       key_accept;
   logic [3:0]       key_press;
   logic [3:0]       edge_cap;
   logic [3:0]       edge_clr;
   logic [3:0]       mask_q;
   logic [13:0]      addr_off;
   logic             addr_hit;
   logic [31:0]      rd_nxt;
   logic             unused_wdata;

   assign unused_wdata     = &{1'b0, writeDataIn[31:4]};
   assign key_pressed_sync = ~key_sync;

   // Two-flop synchronizers; keys come out of reset as released.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         sw_meta  <= '0;
         sw_sync  <= '0;
         key_meta <= 4'hF;
         key_sync <= 4'hF;
      end else begin
         sw_meta  <= SW;
         sw_sync  <= sw_meta;
         key_meta <= KEY;
         key_sync <= key_meta;
      end
   end

   // Per-key debounce: count consecutive cycles the synced pin disagrees
   // with the accepted state; accept on the terminal count.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
         key_stable <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (key_pressed_sync[i] == key_stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == CNT_TC) begin
               key_stable[i] <= key_pressed_sync[i];
               db_cnt[i]     <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // A press event is an accepted change whose new value is "pressed".
   always_comb begin
      key_accept = '0;
      for (int i = 0; i < 4; i++)
         key_accept[i] = (key_pressed_sync[i] != key_stable[i]) && (db_cnt[i] == CNT_TC);
      key_press = key_accept & key_pressed_sync;
   end

   // Address decode, W1C clear mask and read mux (current register contents).
   always_comb begin
      addr_off = dataAddress - BASE_ADDR;
      addr_hit = (dataAddress >= BASE_ADDR) && (addr_off < 14'd4);
      edge_clr = '0;
      if (dataWrEn && addr_hit && (addr_off[1:0] == 2'd2))
         edge_clr = writeDataIn[3:0];
      rd_nxt = '0;
      if (addr_hit) begin
         case (addr_off[1:0])
            2'd0:    rd_nxt = {22'b0, sw_sync};
            2'd1:    rd_nxt = {28'b0, key_stable};
            2'd2:    rd_nxt = {28'b0, edge_cap};
            default: rd_nxt = {28'b0, mask_q};
         endcase
      end
   end

   // Press capture; a same-cycle set beats the clear so no press is lost.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) edge_cap <= '0;
      else       edge_cap <= (edge_cap & ~edge_clr) | key_press;
   end

`ifdef MMIO_INPUT_IRQ_EN
   // Interrupt mask register.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst)
         mask_q <= '0;
      else if (dataWrEn && addr_hit && (addr_off[1:0] == 2'd3))
         mask_q <= writeDataIn[3:0];
   end

   // Level irq, one cycle behind capture/mask.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) irq <= 1'b0;
      else       irq <= |(edge_cap & mask_q);
   end
`else
   assign mask_q = 4'h0;
   assign irq    = 1'b0;
`endif

   // Registered read port, same latency as dataRAM.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         readDataOut <= '0;
         readHit     <= 1'b0;
      end else begin
         readDataOut <= rd_nxt;
         readHit     <= addr_hit;
      end
   end

endmodule

// File: tb/tb_mmio_input_port.sv
// Bench for mmio_input_port: directed steps followed by random traffic, all
// checked against a window-based behavioural model of the peripheral.
module tb_mmio_input_port;

   localparam int          N    = 16;
   localparam logic [13:0] BASE = 14'h3FF8;

   logic        clk = 1'b0;
   logic        nRst = 1'b0;
   logic [13:0] dataAddress = '0;
   logic [31:0] writeDataIn = '0;
   logic        dataWrEn = 1'b0;
   logic [9:0]  SW = '0;
   logic [3:0]  KEY = 4'hF;
   logic [31:0] readDataOut;
   logic        readHit;
   logic        irq;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mmio_input_port #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(N)) dut (
      .clk(clk), .nRst(nRst), .dataAddress(dataAddress), .writeDataIn(writeDataIn),
      .dataWrEn(dataWrEn), .SW(SW), .KEY(KEY), .readDataOut(readDataOut),
      .readHit(readHit), .irq(irq)
   );

   // Model: key_hist[k] is the pressed-pattern sampled k+1 edges ago. A key
   // takes value v once the pin has read v for N consecutive samples ending
   // two edges back (synchronizer delay). Switches are simply 2 edges late.
   logic [3:0]  key_hist [0:N];
   logic [9:0]  sw_hist [0:1];
   logic [3:0]  m_stable, m_cap, m_mask, m_press, m_clr, all_p, all_r;
   logic        m_irq, m_hit;
   logic [31:0] m_rd;
   logic [13:0] m_off;

   always @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         for (int k = 0; k <= N; k++) key_hist[k] = '0;
         sw_hist[0] = '0;
         sw_hist[1] = '0;
         m_stable = '0; m_cap = '0; m_mask = '0;
         m_irq = 1'b0; m_hit = 1'b0; m_rd = '0;
      end else begin
         m_hit = (dataAddress >= BASE) && (dataAddress <= BASE + 14'd3);
         m_off = dataAddress - BASE;
         m_rd  = '0;
         if (m_hit) begin
            case (m_off)
               14'd0:   m_rd = {22'b0, sw_hist[1]};
               14'd1:   m_rd = {28'b0, m_stable};
               14'd2:   m_rd = {28'b0, m_cap};
               default: m_rd = {28'b0, m_mask};
            endcase
         end
`ifdef MMIO_INPUT_IRQ_EN
         m_irq = |(m_cap & m_mask);
         if (dataWrEn && m_hit && m_off == 14'd3) m_mask = writeDataIn[3:0];
`endif
         all_p = 4'hF;
         all_r = 4'hF;
         for (int k = 1; k <= N; k++) begin
            all_p = all_p & key_hist[k];
            all_r = all_r & ~key_hist[k];
         end
         m_press  = all_p & ~m_stable;
         m_stable = (m_stable | all_p) & ~all_r;
         m_clr    = (dataWrEn && m_hit && m_off == 14'd2) ? writeDataIn[3:0] : 4'h0;
         m_cap    = (m_cap & ~m_clr) | m_press;
         for (int k = N; k > 0; k--) key_hist[k] = key_hist[k-1];
         key_hist[0] = ~KEY;
         sw_hist[1]  = sw_hist[0];
         sw_hist[0]  = SW;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      chk("model_rdata", readDataOut, m_rd);
      chk("model_hit", {31'b0, readHit}, {31'b0, m_hit});
      chk("model_irq", {31'b0, irq}, {31'b0, m_irq});
   endtask

   task automatic rd(input logic [13:0] a, output logic [31:0] v);
      dataAddress = a;
      dataWrEn    = 1'b0;
      tick();
      v = readDataOut;
   endtask

   task automatic wr(input logic [13:0] a, input logic [31:0] d);
      dataAddress = a;
      writeDataIn = d;
      dataWrEn    = 1'b1;
      tick();
      dataWrEn    = 1'b0;
      dataAddress = 14'h0;
   endtask

   task automatic wait_cycles(input int n);
      for (int c = 0; c < n; c++) tick();
   endtask

   logic [31:0] v;

   initial begin
      // Reset state
      #3;
      chk("rst_rdata", readDataOut, 32'h0);
      chk("rst_hit", {31'b0, readHit}, 32'h0);
      chk("rst_irq", {31'b0, irq}, 32'h0);
      @(negedge clk); @(negedge clk);
      nRst = 1'b1;

      // Mid-cycle reset clears registered outputs immediately
      SW = 10'h3FF;
      wait_cycles(3);
      rd(BASE, v);
      chk("sw_pre_reset", v, 32'h3FF);
      @(posedge clk); #2;
      nRst = 1'b0;
      #1;
      chk("midrst_rdata", readDataOut, 32'h0);
      chk("midrst_hit", {31'b0, readHit}, 32'h0);
      chk("midrst_irq", {31'b0, irq}, 32'h0);
      @(negedge clk);
      nRst = 1'b1;
      rd(BASE + 14'd1, v);
      chk("key_state_after_rst", v, 32'h0);

      // Switch readback and out-of-range address
      SW = 10'h2A5;
      wait_cycles(3);
      rd(14'h3FF8, v);
      chk("sw_read", v, 32'h2A5);
      chk("sw_hit", {31'b0, readHit}, 32'h1);
      rd(14'h0100, v);
      chk("oob_rdata", v, 32'h0);
      chk("oob_hit", {31'b0, readHit}, 32'h0);

      // Debounce with a bounce, then a clean hold of KEY[0]
      KEY = 4'hE; wait_cycles(2);
      KEY = 4'hF; wait_cycles(5);
      KEY = 4'hE;
      dataAddress = BASE + 14'd1;
      for (int k = 1; k <= N + 4; k++) begin
         tick();
         if (k == N + 2) chk("db_not_yet", readDataOut, 32'h0);
         if (k == N + 3) chk("db_accepted", readDataOut, 32'h1);
      end
      rd(BASE + 14'd2, v);
      chk("edge_key0", v, 32'h1);

      // W1C, then a press landing on the same edge as a clear
      KEY = 4'hC; wait_cycles(N + 4);
      rd(BASE + 14'd2, v);
      chk("edge_0011", v, 32'h3);
      wr(14'h3FFA, 32'h1);
      rd(14'h3FFA, v);
      chk("w1c_bit0", v, 32'h2);
      KEY = 4'hD; wait_cycles(N + 4);
      KEY = 4'hC; wait_cycles(N + 1);
      wr(14'h3FFA, 32'h1);
      rd(14'h3FFA, v);
      chk("set_beats_clear", v, 32'h3);
      KEY = 4'hF; wait_cycles(N + 4);
      wr(14'h3FFA, 32'hFFFF_FFFF);
      rd(14'h3FFA, v);
      chk("clear_all", v, 32'h0);

      // Release edges are not captured
      KEY = 4'h7; wait_cycles(N + 4);
      rd(BASE + 14'd2, v);
      chk("edge_key3", v, 32'h8);
      wr(BASE + 14'd2, 32'h8);
      KEY = 4'hF; wait_cycles(N + 4);
      rd(BASE + 14'd2, v);
      chk("release_not_captured", v, 32'h0);

      // Interrupt path
      wr(14'h3FFB, 32'h4);
      rd(14'h3FFB, v);
`ifdef MMIO_INPUT_IRQ_EN
      chk("mask_read", v, 32'h4);
      KEY = 4'hB;
      wait_cycles(N + 2);
      chk("irq_before", {31'b0, irq}, 32'h0);
      tick();
      chk("irq_set", {31'b0, irq}, 32'h1);
      wr(14'h3FFA, 32'h4);
      chk("irq_hold", {31'b0, irq}, 32'h1);
      tick();
      chk("irq_clear", {31'b0, irq}, 32'h0);
`else
      chk("mask_read_zero", v, 32'h0);
      KEY = 4'hB;
      for (int k = 0; k < N + 4; k++) begin
         tick();
         chk("irq_tied_low", {31'b0, irq}, 32'h0);
      end
      rd(14'h3FFA, v);
      chk("edge_key2", v, 32'h4);
`endif
      KEY = 4'hF;
      wait_cycles(N + 4);

      // Random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 4; i++)
            if ($urandom_range(23, 0) == 0) KEY[i] = ~KEY[i];
         if ($urandom_range(15, 0) == 0) SW = 10'($urandom);
         if ($urandom_range(3, 0) == 0) dataAddress = 14'($urandom);
         else dataAddress = BASE - 14'd1 + 14'($urandom_range(5, 0));
         dataWrEn    = ($urandom_range(3, 0) == 0);
         writeDataIn = $urandom;
         if (c == 1500) nRst = 1'b0;
         if (c == 1503) nRst = 1'b1;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
